// File: rtl/ser_frame_pkg.sv
// Shared definitions for the serial frame controller: state encoding, fill byte
// and the default header byte.
package ser_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_PARITY  = 2'd3
    } frame_state_t;

    localparam logic [7:0] FILL_BYTE         = 8'h00;
    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

endpackage

// File: rtl/ser_sample_fifo.sv
// Two-entry sample FIFO with a combinational head read; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module ser_sample_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_reg [0:1];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == 2'd2);
    assign empty   = (count_reg == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_reg[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ser_frame_ctrl.sv
// Serial frame generator: header byte, PAYLOAD_SAMPLES sample bytes MSB first,
// plus an even-parity bit when SER_FRAME_PARITY_EN is defined.
module ser_frame_ctrl
    import ser_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD       = SYNC_WORD_DEFAULT,
    parameter int         PAYLOAD_SAMPLES = 4
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        TEST_PAT,
    input  logic        SAMPLE_VALID,
    input  logic [7:0]  SAMPLE,
    input  logic        CLR_FLAGS,
    output logic        SAMPLE_READY,
    output logic        DATA_OUT,
    output logic        SYNC,
    output logic        BUSY,
    output logic        OVERRUN,
    output logic        UNDERRUN,
    output logic [15:0] FRAME_CNT
);

    frame_state_t state_reg;
    logic [2:0]   bit_cnt_reg;
    logic [7:0]   byte_cnt_reg;
    logic [7:0]   shift_reg;
    logic [7:0]   test_cnt_reg;
    logic [15:0]  frame_cnt_reg;
    logic         data_out_reg, sync_reg, busy_reg;
    logic         overrun_reg, underrun_reg, test_mode_reg;
`ifdef SER_FRAME_PARITY_EN
    logic         parity_reg;
`endif

    logic       fifo_pop, fifo_push, fifo_full, fifo_empty;
    logic [7:0] fifo_dout;
    logic       byte_end, last_byte, load_payload, payload_end, frame_end;
    logic       start_frame, fill_needed, overrun_set, sample_ready;
    logic [7:0] next_byte;

    ser_sample_fifo #(.WIDTH(8)) u_fifo (
        .clk   (SYS_CLK),
        .srst  (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (SAMPLE),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Byte boundaries: the next payload byte is fetched during the last bit of the current byte.
    assign byte_end     = (bit_cnt_reg == 3'd7);
    assign last_byte    = (byte_cnt_reg == 8'(PAYLOAD_SAMPLES - 1));
    assign load_payload = byte_end && ((state_reg == ST_HEADER) ||
                                       ((state_reg == ST_PAYLOAD) && !last_byte));
    assign payload_end  = byte_end && (state_reg == ST_PAYLOAD) && last_byte;
`ifdef SER_FRAME_PARITY_EN
    assign frame_end    = (state_reg == ST_PARITY);
`else
    assign frame_end    = payload_end;
`endif
    assign start_frame  = ENABLE && ((state_reg == ST_IDLE) || frame_end);

    assign fifo_pop     = load_payload && !test_mode_reg && !fifo_empty;
    assign fill_needed  = load_payload && !test_mode_reg && fifo_empty;
    assign next_byte    = test_mode_reg ? test_cnt_reg : (fifo_empty ? FILL_BYTE : fifo_dout);
    assign sample_ready = !fifo_full || fifo_pop;
    assign fifo_push    = SAMPLE_VALID && sample_ready;
    assign overrun_set  = SAMPLE_VALID && !sample_ready;

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 3'd0;
            byte_cnt_reg  <= 8'd0;
            shift_reg     <= 8'd0;
            test_cnt_reg  <= 8'd0;
            frame_cnt_reg <= 16'd0;
            data_out_reg  <= 1'b0;
            sync_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            underrun_reg  <= 1'b0;
            test_mode_reg <= 1'b0;
`ifdef SER_FRAME_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            // Sticky flags: a set in the same cycle as CLR_FLAGS wins.
            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end else if (CLR_FLAGS) begin
                overrun_reg <= 1'b0;
            end
            if (fill_needed) begin
                underrun_reg <= 1'b1;
            end else if (CLR_FLAGS) begin
                underrun_reg <= 1'b0;
            end

            if (load_payload && test_mode_reg) begin
                test_cnt_reg <= test_cnt_reg + 8'd1;
            end
            if (frame_end) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end

            if (start_frame) begin
                state_reg     <= ST_HEADER;
                shift_reg     <= {SYNC_WORD[6:0], 1'b0};
                data_out_reg  <= SYNC_WORD[7];
                sync_reg      <= 1'b1;
                busy_reg      <= 1'b1;
                bit_cnt_reg   <= 3'd0;
                byte_cnt_reg  <= 8'd0;
                test_mode_reg <= TEST_PAT;
`ifdef SER_FRAME_PARITY_EN
                parity_reg    <= 1'b0;
`endif
            end else if (frame_end) begin
                state_reg    <= ST_IDLE;
                data_out_reg <= 1'b0;
                sync_reg     <= 1'b0;
                busy_reg     <= 1'b0;
                bit_cnt_reg  <= 3'd0;
            end else if (state_reg != ST_IDLE) begin
                sync_reg    <= 1'b0;
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
`ifdef SER_FRAME_PARITY_EN
                parity_reg  <= parity_reg ^ data_out_reg;
`endif
                if (load_payload) begin
                    state_reg    <= ST_PAYLOAD;
                    shift_reg    <= {next_byte[6:0], 1'b0};
                    data_out_reg <= next_byte[7];
                    if (state_reg == ST_PAYLOAD) begin
                        byte_cnt_reg <= byte_cnt_reg + 8'd1;
                    end
`ifdef SER_FRAME_PARITY_EN
                end else if (payload_end) begin
                    state_reg    <= ST_PARITY;
                    data_out_reg <= parity_reg ^ data_out_reg;
`endif
                end else begin
                    data_out_reg <= shift_reg[7];
                    shift_reg    <= {shift_reg[6:0], 1'b0};
                end
            end
        end
    end

    assign SAMPLE_READY = sample_ready;
    assign DATA_OUT     = data_out_reg;
    assign SYNC         = sync_reg;
    assign BUSY         = busy_reg;
    assign OVERRUN      = overrun_reg;
    assign UNDERRUN     = underrun_reg;
    assign FRAME_CNT    = frame_cnt_reg;

endmodule

// File: tb/tb_ser_frame_ctrl.sv
// Bench for ser_frame_ctrl: frame-position model checked every cycle plus directed
// frame captures with literal expectations. Honours SER_FRAME_PARITY_EN.
module tb_ser_frame_ctrl;

    localparam int N = 4;
`ifdef SER_FRAME_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL = 8 + 8 * N + PB;

    logic        SYS_CLK, RST, ENABLE, TEST_PAT, SAMPLE_VALID, CLR_FLAGS;
    logic [7:0]  SAMPLE;
    logic        SAMPLE_READY, DATA_OUT, SYNC, BUSY, OVERRUN, UNDERRUN;
    logic [15:0] FRAME_CNT;

    ser_frame_ctrl #(.SYNC_WORD(8'hA5), .PAYLOAD_SAMPLES(N)) dut (
        .SYS_CLK      (SYS_CLK),
        .RST          (RST),
        .ENABLE       (ENABLE),
        .TEST_PAT     (TEST_PAT),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE       (SAMPLE),
        .CLR_FLAGS    (CLR_FLAGS),
        .SAMPLE_READY (SAMPLE_READY),
        .DATA_OUT     (DATA_OUT),
        .SYNC         (SYNC),
        .BUSY         (BUSY),
        .OVERRUN      (OVERRUN),
        .UNDERRUN     (UNDERRUN),
        .FRAME_CNT    (FRAME_CNT)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position within the frame (-1 = idle), sample queue, sticky flags.
    int          m_pos   = -1;
    logic [7:0]  q[$];
    bit          m_valid = 0;
    bit          m_test, m_par;
    logic [7:0]  m_tcnt, m_cur;
    logic [7:0]  m_sw    = 8'hA5;
    logic        m_data, m_sync, m_busy, m_ovr, m_und;
    logic [15:0] m_fcnt;

    function automatic bit is_byte_start(input int p);
        return (p >= 8) && (p < 8 + 8 * N) && ((p - 8) % 8 == 0);
    endfunction

    function automatic bit m_pop_pending();
        if (m_pos < 0 || m_pos == FL - 1) return 1'b0;
        return is_byte_start(m_pos + 1) && !m_test && (q.size() > 0);
    endfunction

    task automatic model_step();
        int   np;
        logic b;
        if (RST) begin
            m_valid = 1; m_pos = -1; q.delete();
            m_test = 0; m_par = 0; m_tcnt = 8'h00; m_cur = 8'h00;
            m_data = 0; m_sync = 0; m_busy = 0; m_ovr = 0; m_und = 0; m_fcnt = 16'h0;
            return;
        end
        if (!m_valid) return;
        if (m_pos < 0) begin
            np = ENABLE ? 0 : -1;
        end else if (m_pos == FL - 1) begin
            m_fcnt++;
            np = ENABLE ? 0 : -1;
        end else begin
            np = m_pos + 1;
        end
        if (CLR_FLAGS) begin
            m_ovr = 0; m_und = 0;
        end
        if (np == 0) begin
            m_test = TEST_PAT; m_par = 0;
        end
        if (is_byte_start(np)) begin
            if (m_test) begin
                m_cur = m_tcnt; m_tcnt++;
            end else if (q.size() > 0) begin
                m_cur = q.pop_front();
            end else begin
                m_cur = 8'h00; m_und = 1;
            end
        end
        if (SAMPLE_VALID) begin
            if (q.size() < 2) q.push_back(SAMPLE);
            else m_ovr = 1;
        end
        if (np < 0)               b = 1'b0;
        else if (np < 8)          b = m_sw[7 - np];
        else if (np < 8 + 8 * N)  b = m_cur[7 - ((np - 8) % 8)];
        else                      b = m_par;
        if (np >= 0 && np < 8 + 8 * N) m_par = m_par ^ b;
        m_data = b; m_sync = (np == 0); m_busy = (np >= 0); m_pos = np;
    endtask

    initial forever begin
        @(posedge SYS_CLK);
        model_step();
    end

    initial forever begin
        @(negedge SYS_CLK);
        if (m_valid) begin
            chk("data_out", DATA_OUT, m_data);
            chk("sync", SYNC, m_sync);
            chk("busy", BUSY, m_busy);
            chk("overrun", OVERRUN, m_ovr);
            chk("underrun", UNDERRUN, m_und);
            chk("frame_cnt", FRAME_CNT, m_fcnt);
            chk("sample_ready", SAMPLE_READY, (q.size() < 2) || m_pop_pending());
        end
    end

    task automatic tick();
        @(negedge SYS_CLK);
    endtask

    task automatic do_reset();
        RST = 1; ENABLE = 0; TEST_PAT = 0; SAMPLE_VALID = 0; CLR_FLAGS = 0; SAMPLE = 8'h00;
        repeat (3) tick();
        RST = 0;
    endtask

    task automatic push(input logic [7:0] v);
        SAMPLE = v; SAMPLE_VALID = 1;
        tick();
        SAMPLE_VALID = 0;
    endtask

    task automatic clr_flags();
        CLR_FLAGS = 1;
        tick();
        CLR_FLAGS = 0;
    endtask

    task automatic wait_sync(output bit ok);
        int w = 0;
        while (SYNC !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        ok = (SYNC === 1'b1);
        if (!ok) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL sync_wait: SYNC stayed %b, expected 1 within 40 cycles", SYNC);
        end
    endtask

    // Capture one frame starting at SYNC; optional pushes at bit positions p1/p2
    // and ENABLE release at bit drop_at.
    task automatic capture(input int p1, input logic [7:0] s1, input int p2, input logic [7:0] s2,
                           input int drop_at, output logic [39:0] frm, output logic pbit,
                           output int sync_cnt);
        bit ok;
        frm = 40'h0; pbit = 1'b0; sync_cnt = 0;
        wait_sync(ok);
        if (!ok) return;
        for (int i = 0; i < FL; i++) begin
            if (i < 40) frm = {frm[38:0], DATA_OUT};
            else pbit = DATA_OUT;
            if (SYNC === 1'b1) sync_cnt++;
            SAMPLE_VALID = (i == p1) || (i == p2);
            SAMPLE       = (i == p1) ? s1 : s2;
            if (i == drop_at) ENABLE = 0;
            tick();
        end
        SAMPLE_VALID = 0;
    endtask

    logic [39:0] frm;
    logic        pbit;
    int          sc;
    bit          ok;

    initial begin
        RST = 1; ENABLE = 0; TEST_PAT = 0; SAMPLE_VALID = 0; CLR_FLAGS = 0; SAMPLE = 8'h00;
        do_reset();
        chk("rst_data_out", DATA_OUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ready", SAMPLE_READY, 1);
        chk("rst_frame_cnt", FRAME_CNT, 0);

        // Basic frame, samples arriving ahead of their slots.
        push(8'h11); push(8'h22);
        ENABLE = 1;
        capture(10, 8'h33, 18, 8'h44, 30, frm, pbit, sc);
        chk("frame_basic", frm, 40'hA5_11_22_33_44);
        chk("sync_once", sc, 1);
        chk("frame_cnt_1", FRAME_CNT, 1);
        chk("idle_busy", BUSY, 0);
        chk("idle_data", DATA_OUT, 0);
        chk("no_underrun", UNDERRUN, 0);

        // Overrun: third sample is dropped.
        push(8'hA1); push(8'hA2); push(8'hA3);
        chk("overrun_set", OVERRUN, 1);
        chk("ready_full", SAMPLE_READY, 0);
        clr_flags();
        chk("overrun_clr", OVERRUN, 0);

        // Underrun: leftover samples then fill bytes, then an empty frame.
        ENABLE = 1;
        capture(-1, 8'h00, -1, 8'h00, -1, frm, pbit, sc);
        chk("frame_partial", frm, 40'hA5_A1_A2_00_00);
        chk("underrun_set", UNDERRUN, 1);
        capture(-1, 8'h00, -1, 8'h00, 20, frm, pbit, sc);
        chk("frame_fill", frm, 40'hA5_00_00_00_00);
        chk("frame_cnt_3", FRAME_CNT, 3);
        clr_flags();

        // Test pattern: two back-to-back frames, FIFO contents preserved.
        push(8'h5A);
        TEST_PAT = 1; ENABLE = 1;
        capture(-1, 8'h00, -1, 8'h00, -1, frm, pbit, sc);
        chk("frame_tp0", frm, 40'hA5_00_01_02_03);
        capture(-1, 8'h00, -1, 8'h00, 20, frm, pbit, sc);
        chk("frame_tp1", frm, 40'hA5_04_05_06_07);
        TEST_PAT = 0;
        chk("tp_no_underrun", UNDERRUN, 0);
        ENABLE = 1;
        capture(-1, 8'h00, -1, 8'h00, 5, frm, pbit, sc);
        chk("frame_after_tp", frm, 40'hA5_5A_00_00_00);
        clr_flags();

        // ENABLE released early: frame still completes.
        ENABLE = 1;
        capture(-1, 8'h00, -1, 8'h00, 10, frm, pbit, sc);
        chk("frame_drop", frm, 40'hA5_00_00_00_00);
        chk("drop_busy", BUSY, 0);
        chk("drop_data", DATA_OUT, 0);

        // Reset mid-frame aborts without counting.
        do_reset();
        ENABLE = 1;
        wait_sync(ok);
        repeat (20) tick();
        chk("mid_busy", BUSY, 1);
        RST = 1; ENABLE = 0;
        tick();
        chk("abort_busy", BUSY, 0);
        chk("abort_sync", SYNC, 0);
        chk("abort_data", DATA_OUT, 0);
        chk("abort_frame_cnt", FRAME_CNT, 0);
        RST = 0;
        tick();

`ifdef SER_FRAME_PARITY_EN
        push(8'h01);
        ENABLE = 1;
        capture(-1, 8'h00, -1, 8'h00, 5, frm, pbit, sc);
        chk("frame_parity", frm, 40'hA5_01_00_00_00);
        chk("parity_bit", pbit, 1);
        chk("parity_frame_cnt", FRAME_CNT, 1);
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
